// File: rtl/hpi_pkg.sv
// Shared types and constants for the EZ-OTG HPI bus master.
// Optional feature macro: HPI_IRQ_SYNC_EN (synchronised, sticky interrupt flag).
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_IDLE   = 2'd0,
    HPI_SETUP  = 2'd1,
    HPI_STROBE = 2'd2,
    HPI_HOLD   = 2'd3
  } hpi_state_t;

  // HPI status register; a completed read of it acknowledges the interrupt.
  localparam logic [1:0] HPI_STATUS_ADDR = 2'b10;

  // Width of a down-counter that must hold the largest phase length.
  function automatic int hpi_cnt_width(input int setup_cyc, input int strobe_cyc,
                                       input int hold_cyc);
    int max_cyc;
    max_cyc = setup_cyc;
    if (strobe_cyc > max_cyc) begin
      max_cyc = strobe_cyc;
    end
    if (hold_cyc > max_cyc) begin
      max_cyc = hold_cyc;
    end
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/hpi_irq_sync.sv
// Interrupt conditioning for the HPI master: two-flop synchroniser, rising
// edge detect and a sticky flag. Only instantiated when HPI_IRQ_SYNC_EN is defined.
module hpi_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic clear,
  output logic irq
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;
  logic irq_r;
  logic rise;

  assign rise = sync_2 & ~sync_prev;
  assign irq  = irq_r;

  // Synchronise the chip interrupt and hold a sticky flag; a new edge beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      sync_1    <= async_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      if (rise) begin
        irq_r <= 1'b1;
      end else if (clear) begin
        irq_r <= 1'b0;
      end else begin
        irq_r <= irq_r;
      end
    end
  end

endmodule

// File: rtl/hpi_bus_master.sv
// Host-port master for the EZ-OTG HPI bus. One request at a time is accepted
// over valid/ready and sequenced as SETUP -> STROBE -> HOLD on CS_N/RD_N/WR_N.
// Every bus pin except OTG_RST_N comes directly from a flop.
// Optional feature macro: HPI_IRQ_SYNC_EN (sticky, synchronised interrupt).
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              chip_rst,
  output logic              irq,
  inout  wire  [DATA_W-1:0] OTG_DATA,
  output logic [ADDR_W-1:0] OTG_ADDR,
  output logic              OTG_RD_N,
  output logic              OTG_WR_N,
  output logic              OTG_CS_N,
  output logic              OTG_RST_N,
  input  logic              OTG_INT
);

  localparam int CNT_W = hpi_cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  hpi_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              drive_en;
  logic              cs_n_r;
  logic              rd_n_r;
  logic              wr_n_r;
  logic              ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign OTG_ADDR  = addr_r;
  assign OTG_CS_N  = cs_n_r;
  assign OTG_RD_N  = rd_n_r;
  assign OTG_WR_N  = wr_n_r;
  assign OTG_DATA  = drive_en ? wdata_r : {DATA_W{1'bz}};
  assign OTG_RST_N = ~(Reset | chip_rst);

  // Transaction sequencer; each phase reloads the shared down-counter on entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= HPI_IDLE;
      cnt         <= {CNT_W{1'b0}};
      write_r     <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      drive_en    <= 1'b0;
      cs_n_r      <= 1'b1;
      rd_n_r      <= 1'b1;
      wr_n_r      <= 1'b1;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else begin
      rsp_valid_r <= 1'b0;
      case (state)
        HPI_IDLE: begin
          if (req_valid) begin
            state    <= HPI_SETUP;
            cnt      <= SETUP_LOAD;
            write_r  <= req_write;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            drive_en <= req_write;
            cs_n_r   <= 1'b0;
            ready_r  <= 1'b0;
          end else begin
            state <= HPI_IDLE;
          end
        end
        HPI_SETUP: begin
          if (cnt == {CNT_W{1'b0}}) begin
            state  <= HPI_STROBE;
            cnt    <= STROBE_LOAD;
            rd_n_r <= write_r;
            wr_n_r <= ~write_r;
          end else begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        HPI_STROBE: begin
          if (cnt == {CNT_W{1'b0}}) begin
            state  <= HPI_HOLD;
            cnt    <= HOLD_LOAD;
            rd_n_r <= 1'b1;
            wr_n_r <= 1'b1;
            // The chip's read data is still valid on the edge that raises RD_N.
            if (!write_r) begin
              rsp_rdata_r <= OTG_DATA;
            end else begin
              rsp_rdata_r <= rsp_rdata_r;
            end
          end else begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        HPI_HOLD: begin
          if (cnt == {CNT_W{1'b0}}) begin
            state       <= HPI_IDLE;
            cs_n_r      <= 1'b1;
            drive_en    <= 1'b0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b1;
          end else begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state    <= HPI_IDLE;
          cs_n_r   <= 1'b1;
          rd_n_r   <= 1'b1;
          wr_n_r   <= 1'b1;
          drive_en <= 1'b0;
          ready_r  <= 1'b1;
        end
      endcase
    end
  end

`ifdef HPI_IRQ_SYNC_EN
  // write_r/addr_r still describe the finished transaction during the rsp_valid cycle.
  logic status_clear;
  assign status_clear = rsp_valid_r & ~write_r & (addr_r == ADDR_W'(HPI_STATUS_ADDR));

  hpi_irq_sync u_irq_sync (
    .clk      (Clk),
    .rst      (Reset),
    .async_in (OTG_INT),
    .clear    (status_clear),
    .irq      (irq)
  );
`else
  logic irq_r;
  assign irq = irq_r;

  // Plain one-flop registration of the chip interrupt level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= OTG_INT;
    end
  end
`endif

endmodule

// File: tb/tb_hpi_bus_master.sv
// Self-checking bench for hpi_bus_master: directed vector table, random
// transactions against a phase-count model, and multi-cycle corner sequences.
module tb_hpi_bus_master;

  localparam int S_CYC  = 1;
  localparam int ST_CYC = 3;
  localparam int H_CYC  = 1;
  localparam int TXN_LEN = S_CYC + ST_CYC + H_CYC;
  localparam logic [15:0] NOT_DRIVEN = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = 2'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        chip_rst = 1'b0;
  logic        irq;
  wire  [15:0] otg_data;
  logic [1:0]  otg_addr;
  logic        otg_rd_n, otg_wr_n, otg_cs_n, otg_rst_n;
  logic        otg_int = 1'b0;
  logic [15:0] chip_val = 16'd0;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_rdata = 16'd0;

  always #5 clk = ~clk;

  // Chip model: drives read data only while selected and RD_N is low.
  assign otg_data = (!otg_cs_n && !otg_rd_n) ? chip_val : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (otg_data[i]);
  end

  hpi_bus_master dut (
    .Clk(clk), .Reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .chip_rst(chip_rst), .irq(irq),
    .OTG_DATA(otg_data), .OTG_ADDR(otg_addr), .OTG_RD_N(otg_rd_n), .OTG_WR_N(otg_wr_n),
    .OTG_CS_N(otg_cs_n), .OTG_RST_N(otg_rst_n), .OTG_INT(otg_int)
  );

  // Second instance with non-default timing.
  logic        a_valid = 1'b0;
  logic        a_ready, a_rsp_valid, a_irq, a_rd_n, a_wr_n, a_cs_n, a_rst_n;
  logic [15:0] a_rdata;
  logic [1:0]  a_addr_o;
  wire  [15:0] a_data;

  hpi_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut_alt (
    .Clk(clk), .Reset(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(1'b1), .req_addr(2'd3), .req_wdata(16'h5AA5),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .chip_rst(1'b0), .irq(a_irq),
    .OTG_DATA(a_data), .OTG_ADDR(a_addr_o), .OTG_RD_N(a_rd_n), .OTG_WR_N(a_wr_n),
    .OTG_CS_N(a_cs_n), .OTG_RST_N(a_rst_n), .OTG_INT(1'b0)
  );

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] cd;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction, starting just after a rising edge; checks every cycle
  // against the phase-boundary model (setup, strobe, hold lengths).
  task automatic run_txn(input logic w, input logic [1:0] a, input logic [15:0] d,
                         input logic [15:0] cd, input logic [15:0] exp_rdata);
    logic strobe;
    logic [15:0] exp_data;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; chip_val = cd;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
    for (int k = 1; k <= TXN_LEN + 1; k++) begin
      @(negedge clk);
      if (k <= TXN_LEN) begin
        strobe = (k > S_CYC) && (k <= S_CYC + ST_CYC);
        exp_data = w ? d : (strobe ? cd : NOT_DRIVEN);
        chk("cs_n_active", otg_cs_n, 0);
        chk("wr_n", otg_wr_n, !(w && strobe));
        chk("rd_n", otg_rd_n, !(!w && strobe));
        chk("addr", otg_addr, a);
        chk("data", otg_data, exp_data);
        chk("busy_no_rsp", rsp_valid, 0);
        chk("busy_not_ready", req_ready, 0);
      end else begin
        chk("end_cs_n", otg_cs_n, 1);
        chk("end_strobes", {otg_rd_n, otg_wr_n}, 2'b11);
        chk("end_data_off", otg_data, NOT_DRIVEN);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_ready", req_ready, 1);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
    end
    @(posedge clk); #1;
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int nacc, npulse, seen, wr_low, wr_k, lat, held;
    logic w;
    logic [1:0] a;
    logic [15:0] d, cd;

    vecs[0] = '{w: 1'b1, a: 2'd1, d: 16'hA5C3, cd: 16'h0000, exp_rdata: 16'h0000};
    vecs[1] = '{w: 1'b0, a: 2'd2, d: 16'h0000, cd: 16'h1234, exp_rdata: 16'h1234};
    vecs[2] = '{w: 1'b1, a: 2'd3, d: 16'h0001, cd: 16'h9999, exp_rdata: 16'h1234};
    vecs[3] = '{w: 1'b0, a: 2'd0, d: 16'h7777, cd: 16'h8000, exp_rdata: 16'h8000};
    vecs[4] = '{w: 1'b1, a: 2'd2, d: 16'h7E7E, cd: 16'h0000, exp_rdata: 16'h8000};
    vecs[5] = '{w: 1'b0, a: 2'd1, d: 16'h0000, cd: 16'h0000, exp_rdata: 16'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", otg_cs_n, 1);
    chk("rst_rd_wr", {otg_rd_n, otg_wr_n}, 2'b11);
    chk("rst_addr", otg_addr, 0);
    chk("rst_data_off", otg_data, NOT_DRIVEN);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 17'd0);
    chk("rst_irq", irq, 0);
    chk("rst_otg_rst_n", otg_rst_n, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("otg_rst_n_release", otg_rst_n, 1);
    chip_rst = 1'b1; #1;
    chk("chip_rst_pin", otg_rst_n, 0);
    chip_rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].cd, vecs[i].exp_rdata);
    end
    model_rdata = vecs[5].exp_rdata;

    // Random transactions against the model; chip_rst must not disturb them
    for (int i = 0; i < 20; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      if (d == NOT_DRIVEN) d = 16'h0F0F;
      cd = 16'($urandom);
      chip_rst = 1'($urandom_range(0, 1));
      #1 chk("rnd_otg_rst_n", otg_rst_n, !chip_rst);
      if (!w) model_rdata = cd;
      run_txn(w, a, d, cd, model_rdata);
    end
    chip_rst = 1'b0;

    // Interrupt path
`ifdef HPI_IRQ_SYNC_EN
    otg_int = 1'b1;
    @(posedge clk); #1;
    otg_int = 1'b0;
    @(negedge clk); chk("irq_sync_c1", irq, 0);
    @(negedge clk); chk("irq_sync_c2", irq, 0);
    @(negedge clk); chk("irq_sync_c3", irq, 1);
    repeat (4) @(negedge clk);
    chk("irq_sticky", irq, 1);
    @(posedge clk); #1;
    run_txn(1'b0, 2'd1, 16'd0, 16'h4321, 16'h4321);
    chk("irq_kept_other_read", irq, 1);
    run_txn(1'b1, 2'd2, 16'h0102, 16'd0, 16'h4321);
    chk("irq_kept_write_status", irq, 1);
    run_txn(1'b0, 2'd2, 16'd0, 16'h0055, 16'h0055);
    chk("irq_cleared", irq, 0);
`else
    otg_int = 1'b1;
    @(negedge clk); chk("irq_lat0", irq, 0);
    @(negedge clk); chk("irq_level_hi", irq, 1);
    @(posedge clk); #1;
    otg_int = 1'b0;
    @(negedge clk); chk("irq_still_hi", irq, 1);
    @(negedge clk); chk("irq_level_lo", irq, 0);
    @(posedge clk); #1;
`endif

    // Reset in the middle of a write strobe
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 16'hBEE5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_wr_n", otg_wr_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", otg_cs_n, 1);
    chk("abort_wr_n", otg_wr_n, 1);
    chk("abort_data_off", otg_data, NOT_DRIVEN);
    chk("abort_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_late_rsp", seen, 0);
    @(posedge clk); #1;

    // Back-to-back: req_valid held for four requests
    nacc = 0; npulse = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 16'h1000;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      seen = 0;
      if (rsp_valid) npulse++;
      if (req_valid && req_ready) begin
        if (nacc > 0) chk("b2b_accept_on_rsp", rsp_valid, 1);
        chk("b2b_cs_gap", otg_cs_n, 1);
        nacc++;
        seen = 1;
      end
      @(posedge clk); #1;
      if (seen != 0) begin
        if (nacc < 4) begin
          req_addr = 2'(nacc); req_wdata = 16'h1000 + 16'(nacc);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", nacc, 4);
    chk("b2b_rsp_pulses", npulse, 4);

    // Alternate timing instance: SETUP=2, STROBE=1, HOLD=3
    @(negedge clk);
    chk("alt_ready", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    wr_low = 0; wr_k = 0; lat = 0; held = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!a_wr_n) begin wr_low++; wr_k = k; end
      if (a_rsp_valid && lat == 0) lat = k;
      if (wr_k != 0 && k > wr_k && a_wr_n && !a_cs_n && a_data == 16'h5AA5) held++;
    end
    chk("alt_strobe_len", wr_low, 1);
    chk("alt_strobe_pos", wr_k, 3);
    chk("alt_latency", lat, 7);
    chk("alt_hold_len", held, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
